// File: rtl/mix_sequencer.sv
// mix_sequencer: steps mix_layer through its mixing passes,
// driving state/sel/run and strobing capture of each pass result.
module mix_sequencer #(
    parameter int         N_LAYERS   = 3,
    parameter logic [3:0] STATE_BASE = 4'b0011,
    parameter logic [3:0] STATE_IDLE = 4'b0000,
    parameter int         SETTLE     = 1,
    parameter int         TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mix_valid,
    output logic       run_out,
    output logic [3:0] state_out,
    output logic       sel_out,
    output logic       cap_en,
    output logic [1:0] layer_idx,
    output logic       busy,
    output logic       done,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [15:0] LP_SETTLE_LAST  = 16'(SETTLE - 1);
    localparam logic [15:0] LP_TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]  LP_LAST_LAYER   = 2'(N_LAYERS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_set_cnt;
    logic [15:0] r_run_cnt;
    logic [3:0]  r_state_code;
    logic        r_sel;
    logic [1:0]  r_layer;
    logic        r_err;
    logic        w_settled;
    logic        w_timeout;
    logic        w_last_layer;

    assign w_settled    = (r_set_cnt == LP_SETTLE_LAST);
    assign w_last_layer = (r_layer == LP_LAST_LAYER);
    // abort and a late valid both outrank the timeout
    assign w_timeout    = (r_state == S_RUN) && !abort && !mix_valid
                          && (r_run_cnt == LP_TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and decoded outputs; abort suppresses cap/done strobes
    always_comb begin
        w_next  = r_state;
        run_out = 1'b0;
        cap_en  = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_settled) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                run_out = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (mix_valid) begin
                    w_next = S_CAPTURE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_CAPTURE: begin
                cap_en = !abort;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last_layer) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SETUP;
                end
            end
            S_DONE: begin
                done   = !abort;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Settle/run counters and the pass context seen by mix_layer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_set_cnt    <= '0;
            r_run_cnt    <= '0;
            r_state_code <= STATE_IDLE;
            r_sel        <= 1'b0;
            r_layer      <= 2'd0;
            r_err        <= 1'b0;
        end else begin
            r_set_cnt <= (r_state == S_SETUP) ? r_set_cnt + 16'd1 : 16'd0;
            r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + 16'd1 : 16'd0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_err        <= 1'b0;
                    r_layer      <= 2'd0;
                    r_state_code <= STATE_BASE;
                    r_sel        <= 1'b0;
                end
            end else if (w_next == S_IDLE) begin
                r_state_code <= STATE_IDLE;
                r_sel        <= 1'b0;
                r_layer      <= 2'd0;
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end else if (r_state == S_CAPTURE && w_next == S_SETUP) begin
                r_layer      <= r_layer + 2'd1;
                r_state_code <= STATE_BASE + {2'b00, r_layer} + 4'd1;
                r_sel        <= 1'b1;
            end
        end
    end

    assign state_out   = r_state_code;
    assign sel_out     = r_sel;
    assign layer_idx   = r_layer;
    assign err_timeout = r_err;

endmodule

// File: doc/mix_sequencer.md
# mix_sequencer

Controller that runs the `mix_layer` datapath through its three mixing passes (mix-layer `state` codes 4'b0011, 4'b0100, 4'b0101) without testbench hand-holding. It does four things per pass: drives the `state` code, selects the input source, raises and drops `run` around the `valid` handshake, and strobes capture of the pass result for feedback into the next pass. It sits between the top-level sequencer (start/done) and the `mix_layer` instance plus its input mux and feedback register.

## Interface
- `N_LAYERS`, 3: number of passes per job (1..4).
- `STATE_BASE`, 4'b0011: mix-layer state code for pass 0; pass i uses `STATE_BASE+i`.
- `STATE_IDLE`, 4'b0000: state code driven while not running a pass.
- `SETTLE`, 1: cycles `state_out`/`sel_out` are held stable before `run_out` rises (≥1).
- `TIMEOUT`, 200: maximum RUN cycles before abandoning a pass (1..65535).

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `abort` in 1: cancel the current job.
- `mix_valid` in 1: `valid` from `mix_layer`.
- `run_out` out 1: `run` to `mix_layer`.
- `state_out` out 4: `state` to `mix_layer`.
- `sel_out` out 1: input mux select; 0 = external input, 1 = feedback register.
- `cap_en` out 1: one-cycle load strobe, `mix_layer` data_out → feedback register.
- `layer_idx` out 2: current pass index.
- `busy` out 1: high from the cycle after start acceptance through DONE.
- `done` out 1: one-cycle pulse when all passes finish.
- `err_timeout` out 1: sticky timeout flag.

## Operation
- Reset values: `run_out`=0, `state_out`=`STATE_IDLE`, `sel_out`=0, `cap_en`=0, `layer_idx`=0, `busy`=0, `done`=0, `err_timeout`=0. FSM enters IDLE and the counters clear.
- FSM states: IDLE, SETUP, RUN, CAPTURE, DONE.
- IDLE → SETUP on `start`=1:
  - clear `err_timeout`, set `layer_idx`=0.
  - drive `state_out`=`STATE_BASE` and `sel_out`=0.
- SETUP: hold for exactly `SETTLE` cycles, then go to RUN. `run_out`=0 throughout.
- RUN:
  - `run_out`=1 and the RUN cycle counter increments.
  - `mix_valid`=1 → CAPTURE.
  - Counter reaching `TIMEOUT` with no valid → set `err_timeout` and go to IDLE. No `cap_en`, no `done`.
- CAPTURE: `run_out`=0, `cap_en`=1 for one cycle.
  - If `layer_idx` < `N_LAYERS-1`: increment `layer_idx`, set `state_out`=`STATE_BASE+layer_idx+1`, set `sel_out`=1, go to SETUP.
  - Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- On entry to IDLE: `state_out`=`STATE_IDLE`, `sel_out`=0, `layer_idx`=0.
- `start` outside IDLE is ignored and is not queued.
- `abort`=1 in any non-IDLE state → IDLE next cycle:
  - `run_out`=0; no `cap_en`, no `done`; `err_timeout` unchanged.
  - `abort` has priority over `mix_valid` and over timeout in the same cycle.
- `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, the start is accepted.
- `mix_valid` outside RUN is ignored. `mix_valid` in the first RUN cycle is honoured.
- `rst` mid-job: all outputs return to reset values on the next edge, including dropping `run_out`.
- `err_timeout` stays set until the next accepted `start` or `rst`.

## Timing
- `start` sampled at edge 0 → SETUP from cycle 1: `busy`=1 and `state_out` valid.
- `run_out` rises `SETTLE` cycles after SETUP entry.
- `mix_valid` sampled high at edge m:
  - `run_out` is 0 after edge m.
  - `cap_en`=1 in the cycle after edge m; `mix_layer` holds data_out through it.
- `state_out` and `sel_out` change only on the transitions IDLE→SETUP, CAPTURE→SETUP, and → IDLE. They are never changed while `run_out`=1.
- Per pass, with valid seen on RUN cycle L: `SETTLE` + L + 1 cycles. Job total: `N_LAYERS`·(`SETTLE`+L+1) + 1 (DONE) cycles.
- `busy` falls in the cycle after the `done` pulse. A new `start` can be accepted in that same cycle.

## Test plan
- Reset: hold `rst`=1 for 3 cycles mid-RUN → next edge has `run_out`=0, `state_out`=0000, `busy`=0, `err_timeout`=0.
- Nominal job (defaults, mix model asserts valid on RUN cycle 5): `start` at edge 0 → passes use `state_out` 0011/0100/0101 and `sel_out` 0/1/1; three `cap_en` pulses; `done` high in cycle 22; `busy` low in cycle 23.
- Timeout (`TIMEOUT`=10, no valid) → `run_out` high for exactly 10 cycles; then `err_timeout`=1, IDLE, no `cap_en`, no `done`; next `start` clears the flag.
- Abort collision: `abort` and `mix_valid` both high in pass 1 → IDLE next cycle, `cap_en` never pulses for pass 1, `done`=0.
- Start-while-busy: `start` pulses during RUN and CAPTURE → ignored; job completes with exactly one `done`. Back-to-back `start` in the cycle `busy` falls is accepted.
- Early valid: `mix_valid` held high throughout SETUP, then also in the first RUN cycle → CAPTURE after exactly one RUN cycle; a valid pulse in IDLE changes nothing.
